// File: rtl/branch_predict_unit.sv
// Branch target buffer with per-entry saturating direction counters.
// Fetch gets a zero-latency prediction; MEM writes back one resolved outcome per cycle.
module branch_predict_unit #(
    parameter int ENTRIES  = 16,
    parameter int WORD_W   = 32,
    parameter int CTR_W    = 2,
    parameter int INIT_CTR = 1,
    parameter int STAT_W   = 16
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic [WORD_W-1:0] lookup_pc,
    output logic              hit,
    output logic              predict_taken,
    output logic [WORD_W-1:0] predict_npc,
    input  logic              update_en,
    input  logic [WORD_W-1:0] update_pc,
    input  logic              update_taken,
    input  logic [WORD_W-1:0] update_target,
    input  logic              update_mispredict,
    input  logic              clear,
    output logic [STAT_W-1:0] branch_cnt,
    output logic [STAT_W-1:0] mispredict_cnt
);
    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = WORD_W - IDX_W - 2;

    localparam logic [CTR_W-1:0] CTR_MAX  = {CTR_W{1'b1}};
    localparam logic [CTR_W-1:0] CTR_INIT = CTR_W'(INIT_CTR);
    localparam logic [CTR_W-1:0] CTR_WT   = CTR_W'(1) << (CTR_W - 1);

    logic [ENTRIES-1:0] r_valid;
    logic [TAG_W-1:0]   r_tag    [ENTRIES];
    logic [WORD_W-1:0]  r_target [ENTRIES];
    logic [CTR_W-1:0]   r_ctr    [ENTRIES];
    logic [STAT_W-1:0]  r_branch_cnt;
    logic [STAT_W-1:0]  r_mispredict_cnt;

    logic [IDX_W-1:0] w_lk_idx;
    logic [TAG_W-1:0] w_lk_tag;
    logic [IDX_W-1:0] w_up_idx;
    logic [TAG_W-1:0] w_up_tag;
    logic             w_up_hit;
    logic             w_unused_lsb;

    function automatic logic [CTR_W-1:0] ctr_step(input logic [CTR_W-1:0] c, input logic up);
        if (up)
            return (c == CTR_MAX) ? c : c + CTR_W'(1);
        return (c == '0) ? c : c - CTR_W'(1);
    endfunction

    function automatic logic [STAT_W-1:0] stat_inc(input logic [STAT_W-1:0] v);
        return (&v) ? v : v + STAT_W'(1);
    endfunction

    assign w_lk_idx     = lookup_pc[IDX_W+1:2];
    assign w_lk_tag     = lookup_pc[WORD_W-1:IDX_W+2];
    assign w_up_idx     = update_pc[IDX_W+1:2];
    assign w_up_tag     = update_pc[WORD_W-1:IDX_W+2];
    assign w_unused_lsb = ^update_pc[1:0];

    // Lookup reads the current table: same-cycle updates are not bypassed.
    assign hit           = r_valid[w_lk_idx] && (r_tag[w_lk_idx] == w_lk_tag);
    assign predict_taken = hit && r_ctr[w_lk_idx][CTR_W-1];
    assign predict_npc   = predict_taken ? r_target[w_lk_idx] : lookup_pc + WORD_W'(4);

    assign w_up_hit = r_valid[w_up_idx] && (r_tag[w_up_idx] == w_up_tag);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_valid <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                r_tag[i]    <= '0;
                r_target[i] <= '0;
                r_ctr[i]    <= CTR_INIT;
            end
        end else if (clear) begin
            r_valid <= '0;
            for (int i = 0; i < ENTRIES; i++)
                r_ctr[i] <= CTR_INIT;
        end else if (update_en) begin
            if (w_up_hit) begin
                r_ctr[w_up_idx] <= ctr_step(r_ctr[w_up_idx], update_taken);
                if (update_taken)
                    r_target[w_up_idx] <= update_target;
            end else if (update_taken) begin
                // Allocate on a taken miss; not-taken misses leave the table alone.
                r_valid[w_up_idx]  <= 1'b1;
                r_tag[w_up_idx]    <= w_up_tag;
                r_target[w_up_idx] <= update_target;
                r_ctr[w_up_idx]    <= CTR_WT;
            end
        end
    end

    // Statistics ignore clear and saturate at all-ones.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_branch_cnt     <= '0;
            r_mispredict_cnt <= '0;
        end else begin
            if (update_en)
                r_branch_cnt <= stat_inc(r_branch_cnt);
            if (update_en && update_mispredict)
                r_mispredict_cnt <= stat_inc(r_mispredict_cnt);
        end
    end

    assign branch_cnt     = r_branch_cnt;
    assign mispredict_cnt = r_mispredict_cnt;

endmodule

// File: tb/tb_branch_predict_unit.sv
// Scoreboard bench for branch_predict_unit: stimulus pushes expected outputs
// from a behavioural table model; a negedge monitor pops and compares.
module tb_branch_predict_unit;
    localparam int ENTRIES  = 16;
    localparam int WORD_W   = 32;
    localparam int CTR_W    = 2;
    localparam int INIT_CTR = 1;
    localparam int STAT_W   = 16;
    localparam int IDX_W    = 4;
    localparam int CTR_TOP  = 3;
    localparam int STAT_TOP = 65535;

    logic              CLK;
    logic              nRST;
    logic [WORD_W-1:0] lookup_pc;
    logic              hit;
    logic              predict_taken;
    logic [WORD_W-1:0] predict_npc;
    logic              update_en;
    logic [WORD_W-1:0] update_pc;
    logic              update_taken;
    logic [WORD_W-1:0] update_target;
    logic              update_mispredict;
    logic              clear;
    logic [STAT_W-1:0] branch_cnt;
    logic [STAT_W-1:0] mispredict_cnt;

    branch_predict_unit #(
        .ENTRIES(ENTRIES), .WORD_W(WORD_W), .CTR_W(CTR_W),
        .INIT_CTR(INIT_CTR), .STAT_W(STAT_W)
    ) dut (
        .CLK(CLK), .nRST(nRST), .lookup_pc(lookup_pc), .hit(hit),
        .predict_taken(predict_taken), .predict_npc(predict_npc),
        .update_en(update_en), .update_pc(update_pc), .update_taken(update_taken),
        .update_target(update_target), .update_mispredict(update_mispredict),
        .clear(clear), .branch_cnt(branch_cnt), .mispredict_cnt(mispredict_cnt)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [31:0] lpc;
        logic        hit;
        logic        tk;
        logic [31:0] npc;
        logic [15:0] bc;
        logic [15:0] mc;
    } exp_t;

    exp_t q[$];
    int total = 0;
    int bad   = 0;

    // Behavioural model: a table of entries plus two integer tallies.
    bit          m_valid [ENTRIES];
    int unsigned m_tag   [ENTRIES];
    int unsigned m_tgt   [ENTRIES];
    int          m_ctr   [ENTRIES];
    int          m_bc;
    int          m_mc;

    function automatic int unsigned idx_of(input logic [31:0] pc);
        return (pc / 4) % ENTRIES;
    endfunction

    function automatic int unsigned tag_of(input logic [31:0] pc);
        return pc / (4 * ENTRIES);
    endfunction

    function void model_reset();
        for (int i = 0; i < ENTRIES; i++) begin
            m_valid[i] = 0; m_tag[i] = 0; m_tgt[i] = 0; m_ctr[i] = INIT_CTR;
        end
        m_bc = 0;
        m_mc = 0;
    endfunction

    function void model_update(input bit en, input logic [31:0] pc, input bit tk,
                               input logic [31:0] tgt, input bit mp, input bit clr);
        int unsigned i;
        i = idx_of(pc);
        if (en) begin
            if (m_bc < STAT_TOP) m_bc++;
            if (mp && m_mc < STAT_TOP) m_mc++;
        end
        if (clr) begin
            for (int k = 0; k < ENTRIES; k++) begin
                m_valid[k] = 0; m_ctr[k] = INIT_CTR;
            end
        end else if (en) begin
            if (m_valid[i] && m_tag[i] == tag_of(pc)) begin
                if (tk) begin
                    if (m_ctr[i] < CTR_TOP) m_ctr[i]++;
                    m_tgt[i] = tgt;
                end else if (m_ctr[i] > 0) begin
                    m_ctr[i]--;
                end
            end else if (tk) begin
                m_valid[i] = 1; m_tag[i] = tag_of(pc); m_tgt[i] = tgt; m_ctr[i] = 2;
            end
        end
    endfunction

    function void push_expect(input logic [31:0] pc);
        exp_t e;
        int unsigned i;
        i = idx_of(pc);
        e.lpc = pc;
        e.hit = m_valid[i] && m_tag[i] == tag_of(pc);
        e.tk  = e.hit && m_ctr[i] >= 2;
        e.npc = e.tk ? m_tgt[i] : pc + 32'd4;
        e.bc  = 16'(m_bc);
        e.mc  = 16'(m_mc);
        q.push_back(e);
    endfunction

    function void chk(input string name, input logic [31:0] act, input logic [31:0] req,
                      input logic [31:0] pc);
        total++;
        if (act !== req) begin
            bad++;
            if (bad <= 40)
                $display("FAIL %s pc=%h actual=%h required=%h t=%0t", name, pc, act, req, $time);
        end
    endfunction

    always @(negedge CLK) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk("hit",            32'(hit),            32'(e.hit), e.lpc);
            chk("predict_taken",  32'(predict_taken),  32'(e.tk),  e.lpc);
            chk("predict_npc",    predict_npc,         e.npc,      e.lpc);
            chk("branch_cnt",     32'(branch_cnt),     32'(e.bc),  e.lpc);
            chk("mispredict_cnt", 32'(mispredict_cnt), 32'(e.mc),  e.lpc);
        end
    end

    // One cycle: drive inputs, record expectation, then advance model at the edge.
    task automatic step(input logic [31:0] lpc, input bit en, input logic [31:0] upc,
                        input bit tk, input logic [31:0] tgt, input bit mp, input bit clr);
        lookup_pc = lpc; update_en = en; update_pc = upc; update_taken = tk;
        update_target = tgt; update_mispredict = mp; clear = clr;
        push_expect(lpc);
        @(posedge CLK);
        #1;
        model_update(en, upc, tk, tgt, mp, clr);
    endtask

    task automatic look(input logic [31:0] lpc);
        step(lpc, 0, 32'h0, 0, 32'h0, 0, 0);
    endtask

    logic [31:0] pool [8];

    initial begin
        nRST = 1'b0;
        lookup_pc = 32'h40; update_en = 0; update_pc = 0; update_taken = 0;
        update_target = 0; update_mispredict = 0; clear = 0;
        model_reset();
        #1;
        push_expect(32'h40);
        @(negedge CLK);
        #2 nRST = 1'b1;
        @(posedge CLK);
        #1;

        step(32'h40, 1, 32'h40, 1, 32'h100, 1, 0);
        look(32'h40);
        for (int i = 0; i < 3; i++) step(32'h40, 1, 32'h40, 0, 32'h0, 0, 0);
        look(32'h40);
        for (int i = 0; i < 4; i++) step(32'h40, 1, 32'h40, 1, 32'h100, 0, 0);
        look(32'h40);

        step(32'h80, 1, 32'h80, 1, 32'h200, 0, 0);
        look(32'h40);
        look(32'h80);

        step(32'h80, 1, 32'h80, 0, 32'h0, 0, 0);
        look(32'h80);
        step(32'h80, 1, 32'hC0, 1, 32'h300, 0, 1);
        look(32'h80);
        look(32'hC0);
        look(32'hFFFF_FFFE);

        pool[0] = 32'h40;   pool[1] = 32'h80;   pool[2] = 32'hC0;      pool[3] = 32'h44;
        pool[4] = 32'h1004; pool[5] = 32'h2040; pool[6] = 32'hFFFF_FFFC; pool[7] = 32'h3C;
        for (int n = 0; n < 600; n++) begin
            logic [31:0] lp, up;
            lp = pool[$urandom_range(0, 7)] | 32'($urandom_range(0, 3));
            up = pool[$urandom_range(0, 7)] | 32'($urandom_range(0, 3));
            step(lp, $urandom_range(0, 3) != 0, up, $urandom_range(0, 1) == 1,
                 $urandom, $urandom_range(0, 1) == 1, $urandom_range(0, 15) == 0);
        end

        for (int n = 0; n < 65536 + 8; n++)
            step(pool[n % 8], 1, pool[$urandom_range(0, 7)], $urandom_range(0, 1) == 1,
                 $urandom, 1, 0);

        // Asynchronous reset between edges; outputs must show the reset state at once.
        nRST = 1'b0;
        update_en = 0; clear = 0; lookup_pc = 32'h80;
        model_reset();
        push_expect(32'h80);
        @(negedge CLK);
        #2 nRST = 1'b1;
        @(posedge CLK);
        #1;
        look(32'h80);
        look(32'h40);
        step(32'h40, 1, 32'h40, 1, 32'h140, 0, 0);
        look(32'h40);

        for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge CLK);
        #1;
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain actual=%0d required=0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
